// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters.
// Define ARB_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      tx_rdy,
  output logic                      tx_write,
  output logic [DATA_W-1:0]         tx_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [1:0]                state_dbg
);

  // Handshake: a lane's byte is consumed in the cycle where req_valid[k] and
  // req_ready[k] are both high; req_ready is a single-cycle pulse from IDLE only.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    BLANK = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  last;
  logic [N_REQ-1:0] eligible;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             accept;

`ifdef ARB_LOCK_EN
  logic             locked;
  logic [ID_W-1:0]  owner;

  always_comb begin
    eligible = req_valid;
    if (locked) begin
      eligible        = '0;
      eligible[owner] = req_valid[owner];
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  // Search starts one past the previous winner and wraps modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(last) + i) % N_REQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign accept = rst && (state == IDLE) && tx_rdy && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= ID_W'(N_REQ - 1);
      tx_write <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
`ifdef ARB_LOCK_EN
      locked   <= 1'b0;
      owner    <= '0;
`endif
    end else begin
      tx_write <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= WRITE;
            tx_write <= 1'b1;
            tx_data  <= req_data[int'(win)*DATA_W +: DATA_W];
            grant_id <= win;
            last     <= win;
            busy     <= 1'b1;
`ifdef ARB_LOCK_EN
            if (req_last[win]) begin
              locked <= 1'b0;
            end else begin
              locked <= 1'b1;
              owner  <= win;
            end
`endif
          end
        end
        WRITE: state <= BLANK;
        // tx_rdy may still read high from before the load; skip it once.
        BLANK: state <= WAIT;
        WAIT: begin
          if (tx_rdy) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
